// File: rtl/stream_mux_pkg.sv
// Shared types for the two-input stream merge: source index enum and default payload width.
package stream_mux_pkg;

    localparam int unsigned DATA_W_DEFAULT = 8;

    typedef enum logic {
        SRC_IN0 = 1'b0,
        SRC_IN1 = 1'b1
    } src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter holding grant priority and the optional packet lock.
// ARB_PKT_LOCK_EN keeps a source granted from its first beat until its last beat.
module rr_arb2
    import stream_mux_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] valid_i,
    input  logic [1:0] last_i,
    input  logic       load_i,
    input  logic       transfer_i,
    output src_t       grant_o
);

    src_t prio_q, prio_d;
    src_t other;
    logic granted_last;
    logic lock_on;
    src_t lock_src;

    always_comb begin
        if (lock_on) begin
            grant_o = lock_src;
        end else if (valid_i[0] && valid_i[1]) begin
            grant_o = prio_q;
        end else if (valid_i[0]) begin
            grant_o = SRC_IN0;
        end else if (valid_i[1]) begin
            grant_o = SRC_IN1;
        end else begin
            grant_o = prio_q;
        end
    end

    assign other        = (grant_o == SRC_IN0) ? SRC_IN1 : SRC_IN0;
    assign granted_last = (grant_o == SRC_IN1) ? last_i[1] : last_i[0];

`ifdef ARB_PKT_LOCK_EN
    logic lock_q, lock_d;
    src_t lock_src_q, lock_src_d;

    assign lock_on  = lock_q;
    assign lock_src = lock_src_q;

    // Priority only rotates at packet boundaries so packets never interleave.
    always_comb begin
        prio_d     = prio_q;
        lock_d     = lock_q;
        lock_src_d = lock_src_q;
        if (transfer_i && load_i) begin
            if (granted_last) begin
                lock_d = 1'b0;
                prio_d = other;
            end else begin
                lock_d     = 1'b1;
                lock_src_d = grant_o;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q     <= SRC_IN0;
            lock_q     <= 1'b0;
            lock_src_q <= SRC_IN0;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end
`else
    logic unused_last;

    assign lock_on     = 1'b0;
    assign lock_src    = SRC_IN0;
    assign unused_last = granted_last;

    always_comb begin
        prio_d = prio_q;
        if (transfer_i && load_i) begin
            prio_d = other;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= SRC_IN0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

endmodule

// File: rtl/stream_mux2_1_rr.sv
// Round-robin merge of two valid/ready streams into one registered output tagged with its source.
// Define ARB_PKT_LOCK_EN to arbitrate per packet instead of per beat.
module stream_mux2_1_rr
    import stream_mux_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_last,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_src
);

    logic              load;
    logic              transfer;
    src_t              grant;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    src_t              out_src_q, out_src_d;

    // Slot is free or its beat leaves this cycle, so a new beat may enter.
    assign load      = !out_valid_q || out_ready;
    assign in0_ready = load && (grant == SRC_IN0);
    assign in1_ready = load && (grant == SRC_IN1);
    assign transfer  = (in0_valid && in0_ready) || (in1_valid && in1_ready);

    rr_arb2 u_arb (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    ({in1_valid, in0_valid}),
        .last_i     ({in1_last, in0_last}),
        .load_i     (load),
        .transfer_i (transfer),
        .grant_o    (grant)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_src_d   = grant;
            out_data_d  = (grant == SRC_IN1) ? in1_data : in0_data;
            out_last_d  = (grant == SRC_IN1) ? in1_last : in0_last;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= SRC_IN0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux2_1_rr.sv
// Scoreboard bench for stream_mux2_1_rr: a behavioural model predicts grants and beats,
// a separate monitor pops expected beats whenever the output handshakes.
module tb_stream_mux2_1_rr;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in0_valid, in0_ready, in0_last;
    logic         in1_valid, in1_ready, in1_last;
    logic [W-1:0] in0_data, in1_data;
    logic         out_valid, out_ready, out_last, out_src;
    logic [W-1:0] out_data;

    always #5 clk = ~clk;

    stream_mux2_1_rr #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_ready (in0_ready),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in1_valid (in1_valid),
        .in1_ready (in1_ready),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src)
    );

    typedef struct packed {
        logic         src;
        logic         last;
        logic [W-1:0] data;
    } beat_t;

    beat_t        sb[$];
    logic [W:0]   q0[$];   // pending input beats {last, data}
    logic [W:0]   q1[$];
    int           vectors = 0;
    int           miscompares = 0;

    // Model state: what the output slot, priority and packet lock are after the next edge.
    int           m_occ = 0;
    int           m_prio = 0;
    int           m_lock_on = 0;
    int           m_lock_src = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: present queue heads, predict readies, record the accepted beat.
    task automatic cycle(input int unsigned ordy_pct);
        logic [W:0] h0, h1, r;
        logic       v0, v1, ld, t;
        int         g;
        @(posedge clk);
        #1;
        check("out_valid", {31'b0, out_valid}, m_occ);
        v0 = (q0.size() > 0);
        v1 = (q1.size() > 0);
        r  = W'($urandom);
        h0 = v0 ? q0[0] : r;
        r  = {1'($urandom), W'($urandom)};
        h1 = v1 ? q1[0] : r;
        in0_valid = v0;
        in0_last  = h0[W];
        in0_data  = h0[W-1:0];
        in1_valid = v1;
        in1_last  = h1[W];
        in1_data  = h1[W-1:0];
        out_ready = ($urandom_range(99) < ordy_pct);
        #1;
        ld = (m_occ == 0) || out_ready;
        if (m_lock_on != 0)  g = m_lock_src;
        else if (v0 && v1)   g = m_prio;
        else if (v0)         g = 0;
        else if (v1)         g = 1;
        else                 g = m_prio;
        check("in0_ready", {31'b0, in0_ready}, {31'b0, ld && (g == 0)});
        check("in1_ready", {31'b0, in1_ready}, {31'b0, ld && (g == 1)});
        t = ld && ((g == 0) ? v0 : v1);
        if (t) begin
            r = (g == 0) ? q0.pop_front() : q1.pop_front();
            sb.push_back('{src: (g == 1), last: r[W], data: r[W-1:0]});
            m_occ = 1;
`ifdef ARB_PKT_LOCK_EN
            if (r[W]) begin
                m_lock_on = 0;
                m_prio    = 1 - g;
            end else begin
                m_lock_on  = 1;
                m_lock_src = g;
            end
`else
            m_prio = 1 - g;
`endif
        end else if (out_ready) begin
            m_occ = 0;
        end
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        out_ready = 1'($urandom);
        repeat (n) @(posedge clk);
        #1;
        rst        = 1'b0;
        sb.delete();
        m_occ      = 0;
        m_prio     = 0;
        m_lock_on  = 0;
        m_lock_src = 0;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_out_data", {24'b0, out_data}, 0);
        check("rst_out_last", {31'b0, out_last}, 0);
        check("rst_out_src", {31'b0, out_src}, 0);
        check("rst_in0_ready", {31'b0, in0_ready}, 1);
        check("rst_in1_ready", {31'b0, in1_ready}, 0);
    endtask

    // Monitor: a beat presented with out_ready high leaves at the next edge.
    logic         have_prev = 1'b0;
    logic         prev_valid, prev_ready, prev_last, prev_src;
    logic [W-1:0] prev_data;

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                have_prev = 1'b0;
            end else begin
                if (have_prev && prev_valid && !prev_ready) begin
                    check("stall_valid", {31'b0, out_valid}, 1);
                    check("stall_data", {24'b0, out_data}, {24'b0, prev_data});
                    check("stall_last", {31'b0, out_last}, {31'b0, prev_last});
                    check("stall_src", {31'b0, out_src}, {31'b0, prev_src});
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_beat: got %0h expected none", out_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", {24'b0, out_data}, {24'b0, e.data});
                        check("out_last", {31'b0, out_last}, {31'b0, e.last});
                        check("out_src", {31'b0, out_src}, {31'b0, e.src});
                    end
                end
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
                prev_src   = out_src;
                have_prev  = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] rd;
        rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
        in0_data = '0; in1_data = '0; in0_last = 1'b0; in1_last = 1'b0;
        do_reset(2);

        // Single active source streams back to back.
        q0.push_back({1'b0, 8'h11});
        q0.push_back({1'b0, 8'h22});
        q0.push_back({1'b1, 8'h33});
        repeat (5) cycle(100);

        // Constant contention alternates, in0 first after reset.
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            q0.push_back({1'b1, 8'hA0 + 8'(i)});
            q1.push_back({1'b1, 8'hB0 + 8'(i)});
        end
        repeat (10) cycle(100);

        // Stall holds the output beat and blocks both inputs.
        q0.push_back({1'b1, 8'h5A});
        q0.push_back({1'b1, 8'h5B});
        cycle(0);
        repeat (3) cycle(0);
        check("stall_hold_5a", {24'b0, out_data}, 32'h5A);
        repeat (3) cycle(100);

        // Three-beat packet from in0 contending with in1.
        q0.push_back({1'b0, 8'h01});
        q0.push_back({1'b0, 8'h02});
        q0.push_back({1'b1, 8'h03});
        q1.push_back({1'b1, 8'hC1});
        q1.push_back({1'b1, 8'hC2});
        repeat (8) cycle(100);

        // Reset in the middle of a packet drops the held beat.
        q0.push_back({1'b0, 8'h41});
        q0.push_back({1'b0, 8'h42});
        q0.push_back({1'b1, 8'h43});
        q1.push_back({1'b0, 8'h51});
        q1.push_back({1'b1, 8'h52});
        repeat (2) cycle(0);
        do_reset(1);
        repeat (8) cycle(100);

        for (int c = 0; c < 1500; c++) begin
            if (c == 700) do_reset(2);
            if (q0.size() == 0 && $urandom_range(99) < 55) begin
                rd = W'($urandom);
                q0.push_back({($urandom_range(2) == 0), rd});
            end
            if (q1.size() == 0 && $urandom_range(99) < 55) begin
                rd = W'($urandom);
                q1.push_back({($urandom_range(2) == 0), rd});
            end
            cycle(70);
        end

        for (int i = 0; i < 60 && (q0.size() + q1.size() + sb.size()) > 0; i++) cycle(100);
        repeat (2) cycle(100);
        check("drain_pending", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
